// File: rtl/mem_arbiter.sv
// Two-requester arbiter and sequencer for the shared memory port (fetch vs LSU).
// Optional BUSY timeout abort is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
  parameter int unsigned AW         = 16,
  parameter int unsigned DW         = 16,
  parameter int unsigned MAX_STARVE = 3,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_gnt,
  output logic          f_done,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  output logic          l_gnt,
  output logic          l_done,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_rdy
);

  localparam int unsigned SW = $clog2(MAX_STARVE + 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e        state_q;
  logic          own_lsu_q;
  logic [SW-1:0] starve_q;
  logic          f_win;
  logic          finish;
  logic          abort;

  // Fetch takes the port when alone, or when the LSU has starved it long enough.
  assign f_win  = f_req && (!l_req || (starve_q == SW'(MAX_STARVE)));
  assign finish = mem_rdy || abort;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tcnt_q;
  logic          err_q;

  // A completion in the limit cycle wins over the abort.
  assign abort = (state_q == StBusy) && !mem_rdy && (tcnt_q == TW'(TIMEOUT - 1));
  assign err   = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (state_q == StIdle) begin
        tcnt_q <= '0;
      end else if (abort) begin
        err_q  <= 1'b1;
        tcnt_q <= '0;
      end else if (!mem_rdy) begin
        tcnt_q <= tcnt_q + 1'b1;
      end
    end
  end
`else
  logic [31:0] unused_timeout;

  assign unused_timeout = TIMEOUT;
  assign abort          = 1'b0;
  assign err            = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      own_lsu_q <= 1'b0;
      starve_q  <= '0;
      f_gnt     <= 1'b0;
      l_gnt     <= 1'b0;
      f_done    <= 1'b0;
      l_done    <= 1'b0;
      rdata     <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      f_gnt  <= 1'b0;
      l_gnt  <= 1'b0;
      f_done <= 1'b0;
      l_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (f_req || l_req) begin
            state_q <= StBusy;
            mem_en  <= 1'b1;
            if (f_win) begin
              own_lsu_q <= 1'b0;
              f_gnt     <= 1'b1;
              mem_we    <= 1'b0;
              mem_addr  <= f_addr;
              mem_wdata <= '0;
              starve_q  <= '0;
            end else begin
              own_lsu_q <= 1'b1;
              l_gnt     <= 1'b1;
              mem_we    <= l_we;
              mem_addr  <= l_addr;
              mem_wdata <= l_wdata;
              if (!f_req) begin
                starve_q <= '0;
              end else if (starve_q != SW'(MAX_STARVE)) begin
                starve_q <= starve_q + 1'b1;
              end
            end
          end else begin
            starve_q <= '0;
          end
        end
        StBusy: begin
          if (finish) begin
            state_q   <= StIdle;
            f_done    <= !own_lsu_q;
            l_done    <= own_lsu_q;
            rdata     <= (mem_we || !mem_rdy) ? '0 : mem_rdata;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer for the CPU's single shared memory port. Instruction fetch (16-bit address, 24-bit raw instruction fetched by the fetch unit as words) and the LSU both issue requests; the block grants one at a time, drives the memory port for the duration of the access and returns read data with a completion pulse. It sits between the ECU-controlled fetch/LSU datapath and the memory, and is the only master of the memory port.

## Interface
- `AW`, 16, address width
- `DW`, 16, data width
- `MAX_STARVE`, 3, consecutive LSU grants tolerated while fetch waits (≥1)
- `TIMEOUT`, 15, BUSY cycles without `mem_rdy` before abort (used only with the timeout feature)

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset (asserted when 0).
- `f_req` in 1: fetch request, level.
- `f_addr` in AW: fetch address.
- `f_gnt` out 1: one-cycle grant pulse to fetch.
- `f_done` out 1: one-cycle completion pulse to fetch.
- `l_req` in 1: LSU request, level.
- `l_we` in 1: LSU write.
- `l_addr` in AW: LSU address.
- `l_wdata` in DW: LSU write data.
- `l_gnt` out 1: one-cycle grant pulse to LSU.
- `l_done` out 1: one-cycle completion pulse to LSU.
- `rdata` out DW: read data, valid while a done pulse is high.
- `err` out 1: abort flag, valid while a done pulse is high.
- `mem_en` out 1: memory access active.
- `mem_we` out 1: memory write.
- `mem_addr` out AW: memory address.
- `mem_wdata` out DW: memory write data.
- `mem_rdata` in DW: memory read data.
- `mem_rdy` in 1: memory completes the access this cycle.

## Operation
- States: IDLE, BUSY. Reset → IDLE.
- IDLE: if no request, stay. Otherwise select an owner:
  - LSU wins if both request.
  - Fetch wins instead if `starve_cnt == MAX_STARVE`.
- On the selection edge:
  - Latch the owner, address, we and wdata. Fetch is always a read, with wdata 0.
  - Move to BUSY.
  - Pulse the owner's gnt for exactly one cycle.
- BUSY: `mem_en=1`, with `mem_we`, `mem_addr` and `mem_wdata` taken from the latched values, held stable. Requests are ignored.
  - When `mem_rdy=1` is sampled, on that edge: capture `mem_rdata` into `rdata` (0 for writes), pulse the owner's done, and return to IDLE.
- `starve_cnt`: saturating counter, width clog2(MAX_STARVE+1).
  - Increments on each LSU grant made while `f_req=1`.
  - Clears on any fetch grant.
  - Clears on any IDLE cycle with `f_req=0`.
- Requester rules:
  - Hold req, addr and data stable until gnt.
  - Deassert req in the gnt cycle for a single transfer.
  - Req still high when the arbiter returns to IDLE is a new request.
- `err=0` unless the timeout feature aborts an access.
- `rdata` holds its value between done pulses.
- Reset mid-access: the access is abandoned, no done is issued, and all outputs and counters return to 0 immediately.

## Timing
- Reset values: all outputs 0, `starve_cnt=0`, state IDLE.
- Request sampled in IDLE at cycle N → gnt high and `mem_en` high in cycle N+1.
- `mem_rdy` high in cycle M (M ≥ N+1) → done high and `rdata` valid in cycle M+1. `mem_en` is low in M+1 and state is IDLE.
- A new request can be sampled in cycle M+1. Minimum transfer period = 2 cycles, achieved when `mem_rdy` is high in N+1.
- `mem_rdy` is ignored in IDLE.
- Simultaneous `f_req` and `l_req`: exactly one grant. The loser is not queued; it is re-evaluated at the next IDLE.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - A BUSY cycle counter (clog2(TIMEOUT+1) bits) clears on entry to BUSY.
  - When it reaches TIMEOUT with `mem_rdy` still low: the arbiter returns to IDLE, pulses the owner's done with `err=1` and `rdata=0`, and drops `mem_en` in that same next cycle.
  - `mem_rdy` arriving in the same cycle as the limit is a normal completion with `err=0`.
- `MEM_ARB_TIMEOUT_EN` not defined: BUSY waits indefinitely, `err` is tied to 0, and no counter is synthesized.

## Test plan
- Reset: hold `rst=0` with `f_req=l_req=1` and `mem_rdy=1` → all outputs stay 0. Release → `l_gnt` appears on the first cycle after release.
- Fetch read: `f_req` with `f_addr=0x0040`, `mem_rdata=0x1234`, `mem_rdy` 2 cycles after grant → `f_gnt` at N+1, `mem_addr=0x0040` and `mem_en=1` for 3 cycles, then `f_done` with `rdata=0x1234`.
- LSU write: `l_we=1`, `l_addr=0x0100`, `l_wdata=0xBEEF`, `mem_rdy` immediate → `mem_we=1` with the given address/data for 1 cycle, then `l_done` with `rdata=0`, and period 2.
- Contention/starvation: both requests held high continuously, `MAX_STARVE=3` → grant order L, L, L, F, L, L, L, F, and `starve_cnt` never exceeds 3.
- Reset mid-access: assert `rst=0` while BUSY → `mem_en` drops asynchronously and no done pulse appears after release.
- `MEM_ARB_TIMEOUT_EN` with `TIMEOUT=15` and `mem_rdy` held 0 → done pulses after 15 BUSY cycles with `err=1` and `rdata=0`. Without the macro, BUSY persists for 100 cycles with `err=0`.
